param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter_pkg.sv | 18 +
 rtl/param_updown_counter_tick_gen.sv | 37 +++
 rtl/param_updown_counter.sv | 99 +++++++++
 tb/tb_param_updown_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   DIR_UP / DIR_DOWN   : values of the direction input
//   MODE_WRAP / MODE_SAT: values of the SATURATE parameter
//   CLK_HZ              : board clock frequency, default tick divider (1 tick per second)
//   div_cnt_width()     : bit width of a 0..div-1 divider counter (at least 1)
package param_updown_counter_pkg;

    localparam logic        DIR_UP    = 1'b1;
    localparam logic        DIR_DOWN  = 1'b0;
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;
    localparam int unsigned CLK_HZ    = 100000000;

    function automatic int unsigned div_cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/param_updown_counter_tick_gen.sv
// Tick generator: one-cycle registered clock enable every DIV cycles of i_clk.
//   i_clk   : system clock
//   i_clr_n : synchronous active-low clear (divider and tick to 0)
//   o_tick  : high for one cycle after the divider reaches DIV-1; first tick in cycle DIV
module param_updown_counter_tick_gen
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned DIV = CLK_HZ
) (
    input  logic i_clk,
    input  logic i_clr_n,
    output logic o_tick
);

    localparam int unsigned         CntW   = div_cnt_width(DIV);
    localparam logic [CntW-1:0]     CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] r_div;
    logic            r_tick;
    logic            w_div_last;

    // With DIV=1 the divider stays at 0 and w_div_last is permanently high.
    assign w_div_last = (r_div == CntMax);

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_div  <= w_div_last ? '0 : r_div + 1'b1;
            r_tick <= w_div_last;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised load/enable/up-down counter with built-in tick generator.
//   i_clk    : 100 MHz system clock
//   i_clr_n  : synchronous active-low clear, highest priority
//   i_load   : level-sensitive parallel load (clamped to MODULUS-1), beats counting
//   i_d      : load value
//   i_enable : count enable, acted on only in tick cycles
//   i_up     : direction, 1 = increment, 0 = decrement
//   o_q      : current count, range 0..MODULUS-1
//   o_co     : one-cycle carry/borrow pulse with the wrapping or saturating step
//   o_tick   : internal tick, exported for chaining
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned DIV      = CLK_HZ,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_enable,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_q,
    output logic             o_co,
    output logic             o_tick
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_err_width
        $error("param_updown_counter: WIDTH must be 1..31");
    end
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_err_modulus
        $error("param_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (DIV < 1) begin : g_err_div
        $error("param_updown_counter: DIV must be at least 1");
    end

    localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic [WIDTH-1:0] w_q_next;
    logic             w_co_next;
    logic             w_tick;
    logic             w_d_in_range;

    param_updown_counter_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_clr_n (i_clr_n),
        .o_tick  (w_tick)
    );

    // Compare at 32 bits so MODULUS = 2**WIDTH needs no special case.
    assign w_d_in_range = (32'(i_d) < MODULUS);

    // End-of-range is tested before stepping, so q never leaves 0..MODULUS-1.
    always_comb begin
        w_q_next  = r_q;
        w_co_next = 1'b0;
        if (i_load) begin
            w_q_next = w_d_in_range ? i_d : MaxQ;
        end else if (w_tick && i_enable) begin
            if (i_up == DIR_UP) begin
                if (r_q == MaxQ) begin
                    w_co_next = 1'b1;
                    w_q_next  = (SATURATE == MODE_SAT) ? r_q : '0;
                end else begin
                    w_q_next = r_q + 1'b1;
                end
            end else begin
                if (r_q == '0) begin
                    w_co_next = 1'b1;
                    w_q_next  = (SATURATE == MODE_SAT) ? r_q : MaxQ;
                end else begin
                    w_q_next = r_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_q  <= '0;
            r_co <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            r_co <= w_co_next;
        end
    end

    assign o_q    = r_q;
    assign o_co   = r_co;
    assign o_tick = w_tick;

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    // Three instances: A = 16/DIV4/wrap, B = 10/DIV1/saturate, C = 20/DIV3/wrap (5 bits)
    logic       clk = 1'b0;
    logic       a_clr_n = 1'b0, a_load = 1'b0, a_en = 1'b0, a_up = 1'b1;
    logic [3:0] a_d = '0;
    logic       b_clr_n = 1'b0, b_load = 1'b0, b_en = 1'b0, b_up = 1'b1;
    logic [3:0] b_d = '0;
    logic [4:0] c_d = '0;
    logic [3:0] a_q, b_q;
    logic [4:0] c_q;
    logic       a_co, a_tick, b_co, b_tick, c_co, c_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV(4), .SATURATE(0)) dut_a (
        .i_clk(clk), .i_clr_n(a_clr_n), .i_load(a_load), .i_d(a_d), .i_enable(a_en),
        .i_up(a_up), .o_q(a_q), .o_co(a_co), .o_tick(a_tick));
    param_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(1), .SATURATE(1)) dut_b (
        .i_clk(clk), .i_clr_n(b_clr_n), .i_load(b_load), .i_d(b_d), .i_enable(b_en),
        .i_up(b_up), .o_q(b_q), .o_co(b_co), .o_tick(b_tick));
    param_updown_counter #(.WIDTH(5), .MODULUS(20), .DIV(3), .SATURATE(0)) dut_c (
        .i_clk(clk), .i_clr_n(a_clr_n), .i_load(a_load), .i_d(c_d), .i_enable(a_en),
        .i_up(a_up), .o_q(c_q), .o_co(c_co), .o_tick(c_tick));

    // Reference model: n = edges since reset; tick is high after every DIV-th edge.
    typedef struct {
        int q;
        bit co;
        int n;
        bit tick;
    } mstate_t;

    mstate_t ma, mb, mc;

    function automatic mstate_t mstep(mstate_t s, int m, int dv, bit sat,
                                      bit clr_n, bit load, int d, bit en, bit up);
        mstate_t r = s;
        r.co = 1'b0;
        if (!clr_n) begin
            r.q = 0; r.n = 0; r.tick = 1'b0;
            return r;
        end
        r.n    = s.n + 1;
        r.tick = (r.n % dv) == 0;
        if (load) begin
            r.q = (d < m) ? d : m - 1;
        end else if (s.tick && en) begin
            if (up) begin
                if (s.q + 1 >= m) begin r.co = 1'b1; r.q = sat ? s.q : 0; end
                else r.q = s.q + 1;
            end else begin
                if (s.q - 1 < 0) begin r.co = 1'b1; r.q = sat ? s.q : m - 1; end
                else r.q = s.q - 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: advance the models with the inputs present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        ma = mstep(ma, 16, 4, 1'b0, a_clr_n, a_load, int'(a_d), a_en, a_up);
        mb = mstep(mb, 10, 1, 1'b1, b_clr_n, b_load, int'(b_d), b_en, b_up);
        mc = mstep(mc, 20, 3, 1'b0, a_clr_n, a_load, int'(c_d), a_en, a_up);
        #1;
        chk("a_q", 32'(a_q), 32'(ma.q));
        chk("a_co", 32'(a_co), 32'(ma.co));
        chk("a_tick", 32'(a_tick), 32'(ma.tick));
        chk("b_q", 32'(b_q), 32'(mb.q));
        chk("b_co", 32'(b_co), 32'(mb.co));
        chk("b_tick", 32'(b_tick), 32'(mb.tick));
        chk("c_q", 32'(c_q), 32'(mc.q));
        chk("c_co", 32'(c_co), 32'(mc.co));
        chk("c_tick", 32'(c_tick), 32'(mc.tick));
    endtask

    typedef struct {
        bit       clr_n;
        bit       load;
        bit [3:0] d;
        bit       en;
        bit       up;
        int       q;
        bit       co;
        bit       tick;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit clr_n, input bit load, input bit [3:0] d, input bit en,
                       input bit up, input int q, input bit co, input bit tick);
        vec_t v;
        v.clr_n = clr_n; v.load = load; v.d = d; v.en = en; v.up = up;
        v.q = q; v.co = co; v.tick = tick;
        tbl.push_back(v);
    endtask

    task automatic reset_a();
        a_clr_n = 1'b0; a_load = 1'b0;
        step();
        a_clr_n = 1'b1;
    endtask

    initial begin
        ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};

        // Instance B (MODULUS=10, DIV=1, saturate): hand-derived vectors.
        //   clr load d    en up   q  co tick
        add(0, 0, 4'd0,  0, 1,   0, 0, 0);
        add(1, 1, 4'd8,  1, 1,   8, 0, 1);
        add(1, 0, 4'd0,  1, 1,   9, 0, 1);
        add(1, 0, 4'd0,  1, 1,   9, 1, 1);   // held at top, co pulses
        add(1, 0, 4'd0,  1, 1,   9, 1, 1);
        add(1, 0, 4'd0,  1, 0,   8, 0, 1);
        add(1, 0, 4'd0,  1, 0,   7, 0, 1);
        add(1, 0, 4'd0,  0, 0,   7, 0, 1);   // disabled
        add(1, 1, 4'd13, 1, 1,   9, 0, 1);   // clamp
        add(1, 1, 4'd13, 1, 1,   9, 0, 1);   // load held suppresses saturation co
        add(1, 1, 4'd3,  1, 0,   3, 0, 1);
        add(1, 0, 4'd0,  1, 0,   2, 0, 1);
        add(1, 0, 4'd0,  1, 0,   1, 0, 1);
        add(1, 0, 4'd0,  1, 0,   0, 0, 1);
        add(1, 0, 4'd0,  1, 0,   0, 1, 1);   // held at bottom
        add(1, 0, 4'd0,  1, 0,   0, 1, 1);
        add(0, 1, 4'd5,  1, 1,   0, 0, 0);   // clear beats load
        add(1, 0, 4'd0,  1, 1,   0, 0, 1);   // no tick yet on first edge
        add(1, 0, 4'd0,  1, 1,   1, 0, 1);
        add(1, 1, 4'd9,  0, 1,   9, 0, 1);   // boundary load value
        add(1, 0, 4'd0,  1, 1,   9, 1, 1);

        foreach (tbl[i]) begin
            b_clr_n = tbl[i].clr_n; b_load = tbl[i].load; b_d = tbl[i].d;
            b_en = tbl[i].en; b_up = tbl[i].up;
            step();
            chk($sformatf("tbl%0d_q", i), 32'(b_q), 32'(tbl[i].q));
            chk($sformatf("tbl%0d_co", i), 32'(b_co), 32'(tbl[i].co));
            chk($sformatf("tbl%0d_tick", i), 32'(b_tick), 32'(tbl[i].tick));
        end
        b_clr_n = 1'b1; b_load = 1'b0; b_en = 1'b0;

        // A: count up from reset, wrap 15 -> 0.
        a_en = 1'b1; a_up = 1'b1;
        reset_a();
        for (int k = 1; k <= 66; k++) begin
            step();
            if (k == 3) chk("up_tick3", 32'(a_tick), 32'd0);
            if (k == 4) begin chk("up_tick4", 32'(a_tick), 32'd1); chk("up_q4", 32'(a_q), 32'd0); end
            if (k == 5) begin chk("up_q5", 32'(a_q), 32'd1); chk("up_tick5", 32'(a_tick), 32'd0); end
            if (k == 61) chk("up_q61", 32'(a_q), 32'd15);
            if (k == 65) begin chk("wrap_q", 32'(a_q), 32'd0); chk("wrap_co", 32'(a_co), 32'd1); end
            if (k == 66) chk("wrap_co_end", 32'(a_co), 32'd0);
        end

        // A: count down from 0 wraps to 15.
        a_up = 1'b0;
        reset_a();
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 4) chk("dn_q4", 32'(a_q), 32'd0);
            if (k == 5) begin chk("dn_q5", 32'(a_q), 32'd15); chk("dn_co5", 32'(a_co), 32'd1); end
            if (k == 6) chk("dn_co6", 32'(a_co), 32'd0);
            if (k == 9) chk("dn_q9", 32'(a_q), 32'd14);
        end

        // A: clear while load and tick are both active.
        a_up = 1'b1;
        reset_a();
        for (int k = 1; k <= 8; k++) step();
        chk("pre_clr_tick", 32'(a_tick), 32'd1);
        a_clr_n = 1'b0; a_load = 1'b1; a_d = 4'd7;
        step();
        chk("clr_q", 32'(a_q), 32'd0);
        chk("clr_co", 32'(a_co), 32'd0);
        chk("clr_tick", 32'(a_tick), 32'd0);
        a_clr_n = 1'b1; a_load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("rel_tick%0d", k), 32'(a_tick), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("rel_q5", 32'(a_q), 32'd1);

        // A: enable low, tick keeps running and q/co hold.
        a_en = 1'b0;
        reset_a();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("dis_tick%0d", k), 32'(a_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("dis_q%0d", k), 32'(a_q), 32'd0);
            chk($sformatf("dis_co%0d", k), 32'(a_co), 32'd0);
        end

        // Random traffic on all instances against the model.
        for (int k = 0; k < 2000; k++) begin
            a_clr_n = ($urandom_range(0, 59) != 0);
            a_load  = ($urandom_range(0, 9) == 0);
            a_d     = 4'($urandom_range(0, 15));
            c_d     = 5'($urandom_range(0, 31));
            a_en    = ($urandom_range(0, 3) != 0);
            a_up    = ($urandom_range(0, 2) != 0) ? (k[8] == 1'b0) : 1'($urandom_range(0, 1));
            b_clr_n = ($urandom_range(0, 59) != 0);
            b_load  = ($urandom_range(0, 11) == 0);
            b_d     = 4'($urandom_range(0, 15));
            b_en    = ($urandom_range(0, 2) != 0);
            b_up    = (k[5] == 1'b0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
